// File: rtl/pll_reset_sequencer_if.sv
// Signal bundle between the PLL reset sequencer (master) and the PLL/system side (slave).
interface pll_reset_sequencer_if #(
  parameter int MAX_RETRIES = 3
);
  localparam int RETRY_W = $clog2(MAX_RETRIES + 1);

  logic               pll_lock;
  logic               relock_req;
  logic               pll_resetb;
  logic               pll_bypass;
  logic               sys_reset;
  logic               locked;
  logic               failed;
  logic [RETRY_W-1:0] retry_count;

  modport master (
    input  pll_lock, relock_req,
    output pll_resetb, pll_bypass, sys_reset, locked, failed, retry_count
  );

  modport slave (
    output pll_lock, relock_req,
    input  pll_resetb, pll_bypass, sys_reset, locked, failed, retry_count
  );
endinterface

// File: rtl/pll_reset_sequencer.sv
// Reference-clock-domain sequencer for the iCE40 PLL: reset pulse, lock qualification,
// retry/bypass fallback and downstream system reset release.
module pll_reset_sequencer #(
  parameter int RESET_CYCLES  = 16,
  parameter int LOCK_TIMEOUT  = 4096,
  parameter int STABLE_CYCLES = 256,
  parameter int LOSS_FILTER   = 4,
  parameter int MAX_RETRIES   = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  pll_reset_sequencer_if.master  bus
);
  localparam int CNT_MAX = (RESET_CYCLES > LOCK_TIMEOUT - 1)
                         ? ((RESET_CYCLES > STABLE_CYCLES - 1) ? RESET_CYCLES : STABLE_CYCLES - 1)
                         : ((LOCK_TIMEOUT - 1 > STABLE_CYCLES - 1) ? LOCK_TIMEOUT - 1 : STABLE_CYCLES - 1);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int LOSS_W  = $clog2(LOSS_FILTER + 1);
  localparam int RETRY_W = $clog2(MAX_RETRIES + 1);

  typedef enum logic [2:0] {PLL_RST, WAIT_LOCK, STABLE, RUN, BYPASS_RUN} state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [LOSS_W-1:0]  loss, loss_nxt;
  logic [RETRY_W-1:0] retry, retry_nxt;
  logic               lock_p0, lock_p1;
  logic               attempt_fail;
  logic               resetb_q, bypass_q, sys_reset_q, locked_q, failed_q;
  logic               resetb_nxt, bypass_nxt, sys_reset_nxt, locked_nxt, failed_nxt;

  function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_W'(CNT_MAX)) ? v : v + CNT_W'(1);
  endfunction

  function automatic logic [LOSS_W-1:0] loss_inc(input logic [LOSS_W-1:0] v);
    return (v == LOSS_W'(LOSS_FILTER)) ? v : v + LOSS_W'(1);
  endfunction

  function automatic logic [RETRY_W-1:0] retry_inc(input logic [RETRY_W-1:0] v);
    return (v == RETRY_W'(MAX_RETRIES)) ? v : v + RETRY_W'(1);
  endfunction

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    loss_nxt     = loss;
    retry_nxt    = retry;
    attempt_fail = 1'b0;
    case (state)
      PLL_RST: begin
        if (cnt == CNT_W'(RESET_CYCLES - 1)) begin
          state_nxt = WAIT_LOCK;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt_inc(cnt);
        end
      end
      WAIT_LOCK: begin
        if (lock_p1) begin
          state_nxt = STABLE;
          cnt_nxt   = '0;
        end else if (cnt == CNT_W'(LOCK_TIMEOUT - 1)) begin
          attempt_fail = 1'b1;
        end else begin
          cnt_nxt = cnt_inc(cnt);
        end
      end
      STABLE: begin
        if (!lock_p1) begin
          attempt_fail = 1'b1;
        end else if (cnt == CNT_W'(STABLE_CYCLES - 1)) begin
          state_nxt = RUN;
          cnt_nxt   = '0;
          loss_nxt  = '0;
          retry_nxt = '0;
        end else begin
          cnt_nxt = cnt_inc(cnt);
        end
      end
      RUN: begin
        // Short lock dropouts are filtered; only a sustained loss re-sequences.
        if (lock_p1) begin
          loss_nxt = '0;
        end else if (loss == LOSS_W'(LOSS_FILTER - 1)) begin
          state_nxt = PLL_RST;
          loss_nxt  = '0;
          cnt_nxt   = '0;
        end else begin
          loss_nxt = loss_inc(loss);
        end
      end
      BYPASS_RUN: begin
        if (cnt < CNT_W'(RESET_CYCLES)) cnt_nxt = cnt_inc(cnt);
      end
      default: begin
        state_nxt = PLL_RST;
        cnt_nxt   = '0;
      end
    endcase

    if (attempt_fail) begin
      retry_nxt = retry_inc(retry);
      cnt_nxt   = '0;
      state_nxt = (retry >= RETRY_W'(MAX_RETRIES - 1)) ? BYPASS_RUN : PLL_RST;
    end

    if (bus.relock_req) begin
      state_nxt = PLL_RST;
      cnt_nxt   = '0;
      loss_nxt  = '0;
      retry_nxt = '0;
    end

    // Outputs are decoded from the next state so they register glitch-free with it.
    resetb_nxt    = (state_nxt == WAIT_LOCK) || (state_nxt == STABLE) || (state_nxt == RUN);
    bypass_nxt    = (state_nxt == BYPASS_RUN);
    sys_reset_nxt = !((state_nxt == RUN) ||
                      ((state_nxt == BYPASS_RUN) && (cnt_nxt >= CNT_W'(RESET_CYCLES))));
    locked_nxt    = (state_nxt == RUN);
    failed_nxt    = (state_nxt == BYPASS_RUN);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= PLL_RST;
      cnt         <= '0;
      loss        <= '0;
      retry       <= '0;
      lock_p0     <= 1'b0;
      lock_p1     <= 1'b0;
      resetb_q    <= 1'b0;
      bypass_q    <= 1'b0;
      sys_reset_q <= 1'b1;
      locked_q    <= 1'b0;
      failed_q    <= 1'b0;
    end else begin
      lock_p0     <= bus.pll_lock;
      lock_p1     <= lock_p0;
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      loss        <= loss_nxt;
      retry       <= retry_nxt;
      resetb_q    <= resetb_nxt;
      bypass_q    <= bypass_nxt;
      sys_reset_q <= sys_reset_nxt;
      locked_q    <= locked_nxt;
      failed_q    <= failed_nxt;
    end
  end

  assign bus.pll_resetb  = resetb_q;
  assign bus.pll_bypass  = bypass_q;
  assign bus.sys_reset   = sys_reset_q;
  assign bus.locked      = locked_q;
  assign bus.failed      = failed_q;
  assign bus.retry_count = retry;
endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Table-driven bench for pll_reset_sequencer with a due-cycle scoreboard and hand-written corner sequences.
module tb_pll_reset_sequencer;
  logic clk;
  logic reset;
  int   cyc;
  int   checks;
  int   errors;

  pll_reset_sequencer_if #(.MAX_RETRIES(2)) bus ();

  pll_reset_sequencer #(
    .RESET_CYCLES (4),
    .LOCK_TIMEOUT (64),
    .STABLE_CYCLES(16),
    .LOSS_FILTER  (3),
    .MAX_RETRIES  (2)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // Packed outputs: {pll_resetb, pll_bypass, sys_reset, locked, failed, retry_count[1:0]}
  typedef struct {
    bit         rst;
    bit         lock;
    bit         relock;
    int         n;
    logic [6:0] exp;
  } vec_t;

  typedef struct {
    int         due;
    int         row;
    logic [6:0] exp;
  } sb_ent_t;

  vec_t    vt[$];
  sb_ent_t sb[$];
  sb_ent_t cur;
  logic [6:0] act;

  assign act = {bus.pll_resetb, bus.pll_bypass, bus.sys_reset, bus.locked, bus.failed, bus.retry_count};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [6:0] o_rst(int r);
    return {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'(r)};
  endfunction
  function automatic logic [6:0] o_wt(int r);
    return {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'(r)};
  endfunction
  function automatic logic [6:0] o_run();
    return {1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0};
  endfunction
  function automatic logic [6:0] o_byp(bit s);
    return {1'b0, 1'b1, s, 1'b0, 1'b1, 2'd2};
  endfunction

  task automatic add(bit rst, bit lock, bit relock, int n, logic [6:0] e);
    vec_t v;
    v.rst = rst; v.lock = lock; v.relock = relock; v.n = n; v.exp = e;
    vt.push_back(v);
  endtask

  task automatic check(string name, int got, int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  // Scoreboard pop plus a per-cycle safety invariant on the reset outputs.
  always @(negedge clk) begin
    if (sb.size() != 0 && sb[0].due <= cyc) begin
      cur = sb.pop_front();
      checks++;
      if (cur.due != cyc || act !== cur.exp) begin
        errors++;
        $display("FAIL row%0d at cycle %0d (due %0d): got %b want %b", cur.row, cyc, cur.due, act, cur.exp);
      end
    end
    if (cyc > 0) begin
      checks++;
      if (bus.sys_reset === 1'b0 && bus.pll_resetb === 1'b0 && bus.pll_bypass !== 1'b1) begin
        errors++;
        $display("FAIL sys_reset_guard at cycle %0d: sys_reset=%b pll_resetb=%b bypass=%b",
                 cyc, bus.sys_reset, bus.pll_resetb, bus.pll_bypass);
      end
    end
  end

  initial begin
    int k;
    sb_ent_t e;
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    bus.pll_lock   = 1'b0;
    bus.relock_req = 1'b0;

    // reset, then clean lock 10 cycles after pll_resetb rises
    add(1, 0, 0,  3, o_rst(0));
    add(0, 0, 0,  3, o_rst(0));
    add(0, 0, 0,  1, o_wt(0));
    add(0, 0, 0, 10, o_wt(0));
    add(0, 1, 0, 18, o_wt(0));
    add(0, 1, 0,  1, o_run());
    // loss filter: 2-cycle drop tolerated, longer drop re-sequences without a retry
    add(0, 0, 0,  2, o_run());
    add(0, 1, 0,  6, o_run());
    add(0, 0, 0,  4, o_run());
    add(0, 0, 0,  1, o_rst(0));
    add(0, 0, 0,  3, o_rst(0));
    add(0, 0, 0,  1, o_wt(0));
    // two lock timeouts lead to bypass
    add(0, 0, 0, 63, o_wt(0));
    add(0, 0, 0,  1, o_rst(1));
    add(0, 0, 0,  3, o_rst(1));
    add(0, 0, 0,  1, o_wt(1));
    add(0, 0, 0, 63, o_wt(1));
    add(0, 0, 0,  1, o_byp(1));
    add(0, 0, 0,  3, o_byp(1));
    add(0, 0, 0,  1, o_byp(0));
    add(0, 0, 0, 20, o_byp(0));
    // relock_req together with a lock edge, then a glitch at STABLE cycle 8
    add(0, 1, 1,  1, o_rst(0));
    add(0, 1, 0,  3, o_rst(0));
    add(0, 1, 0,  1, o_wt(0));
    add(0, 1, 0,  9, o_wt(0));
    add(0, 0, 0,  1, o_wt(0));
    add(0, 1, 0,  1, o_wt(0));
    add(0, 1, 0,  1, o_rst(1));
    add(0, 1, 0,  3, o_rst(1));
    add(0, 1, 0,  1, o_wt(1));
    add(0, 1, 0, 16, o_wt(1));
    add(0, 1, 0,  1, o_run());
    // relock from RUN, then a one-cycle reset mid-STABLE and a full sequence
    add(0, 1, 1,  1, o_rst(0));
    add(0, 1, 0,  4, o_wt(0));
    add(0, 1, 0,  6, o_wt(0));
    add(1, 1, 0,  1, o_rst(0));
    add(0, 1, 0,  3, o_rst(0));
    add(0, 1, 0,  1, o_wt(0));
    add(0, 1, 0,  1, o_wt(0));
    add(0, 1, 0, 15, o_wt(0));
    add(0, 1, 0,  1, o_run());

    for (int i = 0; i < vt.size(); i++) begin
      reset          = vt[i].rst;
      bus.pll_lock   = vt[i].lock;
      bus.relock_req = vt[i].relock;
      e.due = cyc + vt[i].n;
      e.row = i;
      e.exp = vt[i].exp;
      sb.push_back(e);
      repeat (vt[i].n) @(posedge clk);
      #1;
    end

    // Sustained loss from RUN: sys_reset and pll_resetb change on the same edge.
    bus.relock_req = 1'b0;
    bus.pll_lock   = 1'b0;
    k = 0;
    while (k < 20 && bus.sys_reset !== 1'b1) begin
      @(posedge clk); #1;
      k++;
    end
    check("loss_to_sys_reset_cycles", k, 5);
    check("loss_pll_resetb", int'(bus.pll_resetb), 0);
    check("loss_retry_count", int'(bus.retry_count), 0);

    // Relock after loss: lock present from PLL_RST entry reaches RUN in 21 cycles.
    bus.pll_lock = 1'b1;
    k = 0;
    while (k < 200 && bus.locked !== 1'b1) begin
      @(posedge clk); #1;
      k++;
    end
    check("relock_to_run_cycles", k, 21);
    check("relock_sys_reset", int'(bus.sys_reset), 0);

    repeat (2) @(posedge clk);
    #1;
    check("scoreboard_drained", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pll_reset_sequencer.md
Name: pll_reset_sequencer

Overview:
Controller for the iCE40 PLL core wrapper. It runs in the reference-clock domain and owns the PLL's RESETB and BYPASS pins. It pulses the PLL reset, waits for a stable LOCK, and only then releases the downstream system reset. It retries on lock timeout, falls back to bypass after repeated failures, and re-sequences on lock loss.

Parameters:
RESET_CYCLES, 16, cycles pll_resetb is held low per attempt (>=1)
LOCK_TIMEOUT, 4096, cycles allowed in WAIT_LOCK before the attempt fails
STABLE_CYCLES, 256, consecutive synced-lock-high cycles required before releasing sys_reset
LOSS_FILTER, 4, consecutive synced-lock-low cycles in RUN treated as real lock loss (>=1)
MAX_RETRIES, 3, failed attempts tolerated before entering BYPASS_RUN (>=1)

Ports:
clk  input  1  reference clock (same net as PLL REFERENCECLK)
reset  input  1  synchronous, active-high
pll_lock  input  1  PLL LOCK, asynchronous to clk
pll_resetb  output  1  to PLL RESETB, active-low
pll_bypass  output  1  to PLL BYPASS
sys_reset  output  1  active-high reset for logic clocked by PLLOUTGLOBAL
locked  output  1  high only in RUN
failed  output  1  high only in BYPASS_RUN
retry_count  output  $clog2(MAX_RETRIES+1)  failed attempts since last reset/RUN entry
relock_req  input  1  single-cycle pulse: force full re-sequence from any state

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high, named reset. All state is updated on posedge clk only.
- Reset values: pll_resetb=0, pll_bypass=0, sys_reset=1, locked=0, failed=0, retry_count=0, state=PLL_RST, all counters 0, lock synchroniser flops 0.
- pll_lock passes through a 2-flop synchroniser to produce lock_s. All lock decisions use lock_s, so there is 2 cycles of latency.
- All outputs are registered and decoded from the state register.
- State machine:
  - PLL_RST: pll_resetb=0, sys_reset=1. The counter counts RESET_CYCLES cycles, then the FSM moves to WAIT_LOCK and clears the counter.
  - WAIT_LOCK: pll_resetb=1.
    - If lock_s=1, go to STABLE and clear the counter.
    - If the counter reaches LOCK_TIMEOUT-1 with lock_s=0, the attempt fails.
  - STABLE: pll_resetb=1, sys_reset=1.
    - Any lock_s=0 cycle is a failed attempt.
    - STABLE_CYCLES consecutive lock_s=1 cycles go to RUN.
  - RUN: sys_reset=0, locked=1, retry_count cleared on entry.
    - A loss counter increments on each lock_s=0 cycle and clears on each lock_s=1 cycle.
    - When it reaches LOSS_FILTER, go to PLL_RST. Lock loss is not counted as a failed attempt.
    - sys_reset reasserts in the same cycle the state leaves RUN.
  - Failed attempt: increment retry_count.
    - If retry_count was MAX_RETRIES-1, go to BYPASS_RUN.
    - Otherwise go to PLL_RST.
  - BYPASS_RUN: pll_bypass=1, pll_resetb=0, sys_reset held 1 for RESET_CYCLES cycles then 0, failed=1.
    - Terminal until reset or relock_req.
    - retry_count saturates at MAX_RETRIES.
- relock_req: from any state, go to PLL_RST next cycle and clear retry_count and counters. It has priority over all other transitions in the same cycle.
- sys_reset is never 0 while pll_resetb=0, except in BYPASS_RUN.
- Counters are sized $clog2 of their maximum, saturate, and never wrap.
- reset asserted mid-sequence returns to the reset values next cycle regardless of state.

Test Plan:
Use RESET_CYCLES=4, LOCK_TIMEOUT=64, STABLE_CYCLES=16, LOSS_FILTER=3, MAX_RETRIES=2.
1. Clean lock: release reset, assert pll_lock 10 cycles after pll_resetb rises and hold it -> pll_resetb low exactly 4 cycles; sys_reset falls 2+16 cycles after pll_lock rises (+/-1 for the synchroniser edge); locked=1; retry_count=0.
2. Lock glitch in STABLE: drop pll_lock for 1 cycle at STABLE cycle 8 -> retry_count=1; pll_resetb low again for 4 cycles; sys_reset never deasserts; a second clean lock then reaches RUN with retry_count=0.
3. Timeout to bypass: hold pll_lock=0 -> pll_resetb pulses twice, each WAIT_LOCK lasting 64 cycles; then pll_bypass=1 and failed=1; sys_reset falls 4 cycles after BYPASS_RUN entry; retry_count=2.
4. Loss filter: in RUN, drop pll_lock for 2 cycles -> stays in RUN with sys_reset=0. Drop it for 3 or more cycles -> sys_reset=1 and pll_resetb=0 on the cycle the filter count reaches 3; retry_count unchanged.
5. relock_req in BYPASS_RUN, asserted in the same cycle as a lock edge -> next cycle state=PLL_RST, pll_bypass=0, failed=0, retry_count=0.
6. Assert reset for 1 cycle mid-STABLE -> all outputs at their reset values next cycle, followed by a full sequence.
